// File: rtl/wb_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for the Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {StIdle, StOwn, StRelease} arb_state_t;

  localparam int unsigned MaxReq        = 8;
  localparam int unsigned IdxMaxW       = 3;
  localparam int unsigned DefNumReq     = 2;
  localparam int unsigned DefAddrW      = 2;
  localparam int unsigned DefDataW      = 8;
  localparam int unsigned DefTimeoutCyc = 64;

  // First requesting index scanning upward from last+1, wrapping modulo n.
  function automatic logic [IdxMaxW-1:0] rr_pick(input logic [MaxReq-1:0]  req,
                                                 input logic [IdxMaxW-1:0] last,
                                                 input int unsigned        n);
    logic [IdxMaxW-1:0] pick;
    logic               found;
    int unsigned        k;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      k = (32'(last) + i) % n;
      if (i <= n && !found && req[k[IdxMaxW-1:0]]) begin
        pick  = k[IdxMaxW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: request vector plus last owner gives next index and valid.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = IdxW'(rr_pick(MaxReq'(req_i), IdxMaxW'(last_i), NUM_REQ));
    valid_o = |req_i;
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave port between NUM_REQ requesters.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_cyc_i,
  input  logic [NUM_REQ-1:0]        req_stb_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_dat_i,
  output logic [DATA_W-1:0]         req_dat_o,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [ADDR_W-1:0]         wb_adr_o,
  output logic [DATA_W-1:0]         wb_dat_o,
  input  logic [DATA_W-1:0]         wb_dat_i,
  input  logic                      wb_ack_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t         state_q;
  logic [IdxW-1:0]    owner_q, last_q, pick_idx;
  logic [NUM_REQ-1:0] grant_q, eligible;
  logic               busy_q, pick_valid, own_cyc, own_stb, timeout;

  assign own_cyc = req_cyc_i[owner_q];
  assign own_stb = req_stb_i[owner_q];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0]    tmo_q;
  logic [NUM_REQ-1:0] revoked_q;

  assign timeout  = busy_q && (tmo_q == CntW'(TIMEOUT_CYC));
  // A revoked owner stays ineligible until it has dropped cyc once.
  assign eligible = req_cyc_i & ~revoked_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q     <= '0;
      revoked_q <= '0;
    end else begin
      if (!busy_q || wb_ack_i || timeout) tmo_q <= '0;
      else if (own_stb)                   tmo_q <= tmo_q + 1'b1;
      revoked_q <= (revoked_q & req_cyc_i) | (timeout ? grant_q : '0);
    end
  end
`else
  // TIMEOUT_CYC is only meaningful with the watchdog built in.
  assign timeout  = (TIMEOUT_CYC == 0) && 1'b0;
  assign eligible = req_cyc_i;
`endif

  wb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (eligible),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StOwn;
            owner_q <= pick_idx;
            grant_q <= NUM_REQ'(1) << pick_idx;
            busy_q  <= 1'b1;
          end
        end
        StOwn: begin
          if (!own_cyc || timeout) begin
            state_q <= StRelease;
            last_q  <= owner_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Slave side follows the owner combinationally so an abandoned access drops cyc at once.
  always_comb begin
    wb_cyc_o  = busy_q & own_cyc;
    wb_stb_o  = busy_q & own_stb & ~timeout;
    wb_we_o   = busy_q & req_we_i[owner_q];
    wb_adr_o  = busy_q ? req_adr_i[owner_q*ADDR_W +: ADDR_W] : '0;
    wb_dat_o  = busy_q ? req_dat_i[owner_q*DATA_W +: DATA_W] : '0;
    req_ack_o = (busy_q && own_cyc && wb_ack_i) ? grant_q : '0;
    req_err_o = timeout ? grant_q : '0;
    req_dat_o = wb_dat_i;
    grant_o   = grant_q;
    busy_o    = busy_q;
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed table, corner sequences, random vs. model.
module tb_wb_bus_arbiter;

  localparam int N   = 2;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [3:0]  adr;
  logic [15:0] dat;
  logic        wb_ack;
  logic [7:0]  wb_dat;

  logic [7:0]  req_dat_o;
  logic [1:0]  req_ack_o, req_err_o, grant_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, busy_o;
  logic [1:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (2),
    .DATA_W      (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_cyc_i (cyc),
    .req_stb_i (stb),
    .req_we_i  (we),
    .req_adr_i (adr),
    .req_dat_i (dat),
    .req_dat_o (req_dat_o),
    .req_ack_o (req_ack_o),
    .req_err_o (req_err_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat),
    .wb_ack_i  (wb_ack),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  // Behavioural model: owner index (-1 = nobody), dead-cycle flag, round-robin pointer.
  int         m_own, m_last, m_stall;
  bit         m_rel;
  logic [1:0] m_revoked;

  function automatic bit m_timeout();
`ifdef WB_ARB_TIMEOUT_EN
    return (m_own >= 0) && (m_stall == TMO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_rel = 0; m_last = N - 1; m_stall = 0; m_revoked = '0;
    end else begin
      bit         to;
      logic [1:0] elig;
      to   = m_timeout();
      elig = cyc & ~m_revoked;
      m_revoked = (m_revoked & cyc) | (to ? 2'(1 << m_own) : 2'b00);
      if (m_own >= 0) begin
        if (!cyc[m_own] || to) begin
          m_last = m_own; m_own = -1; m_rel = 1; m_stall = 0;
        end else if (wb_ack) m_stall = 0;
        else if (stb[m_own]) m_stall++;
      end else if (m_rel) begin
        m_rel = 0;
      end else begin
        for (int i = 1; i <= N; i++) begin
          if (m_own < 0 && elig[(m_last + i) % N]) m_own = (m_last + i) % N;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] eg;
    bit         own, oc;
    own = (m_own >= 0);
    eg  = own ? 2'(1 << m_own) : 2'b00;
    oc  = own && cyc[m_own];
    chk({tag, ".grant"}, grant_o, eg);
    chk({tag, ".busy"}, busy_o, own);
    chk({tag, ".wb_cyc"}, wb_cyc_o, oc);
    chk({tag, ".wb_stb"}, wb_stb_o, own && stb[m_own] && !m_timeout());
    chk({tag, ".wb_we"}, wb_we_o, own && we[m_own]);
    chk({tag, ".wb_adr"}, wb_adr_o, own ? adr[m_own*2 +: 2] : 2'd0);
    chk({tag, ".wb_dat"}, wb_dat_o, own ? dat[m_own*8 +: 8] : 8'd0);
    chk({tag, ".ack"}, req_ack_o, (oc && wb_ack) ? eg : 2'b00);
    chk({tag, ".err"}, req_err_o, m_timeout() ? eg : 2'b00);
    chk({tag, ".rdat"}, req_dat_o, wb_dat);
  endtask

  task automatic do_reset();
    rst_n = 0; cyc = 0; stb = 0; we = 0; adr = 0; dat = 0; wb_ack = 0; wb_dat = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    logic [1:0] cyc, stb, we; logic [3:0] adr; logic [15:0] dat; logic ack; logic [7:0] rdat;
    logic [1:0] e_grant; logic e_cyc, e_stb, e_we; logic [1:0] e_adr; logic [7:0] e_dat;
    logic [1:0] e_ack;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [1:0] prev_ack, last_g;
    logic [1:0] owners[$];
    int         gaps[$];
    int         zrun;

    //         cyc    stb    we     adr   dat       ack   rdat   grant c  s  w  adr   dat    ack
    tbl[0]  = '{2'b01, 2'b01, 2'b01, 4'hE, 16'hFF8C, 1'b0, 8'h00, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'b00};
    tbl[1]  = '{2'b11, 2'b11, 2'b11, 4'hE, 16'hFF8C, 1'b0, 8'h00, 2'b01, 1, 1, 1, 2'd2, 8'h8C, 2'b00};
    tbl[2]  = '{2'b11, 2'b11, 2'b11, 4'hE, 16'hFF8C, 1'b1, 8'h33, 2'b01, 1, 1, 1, 2'd2, 8'h8C, 2'b01};
    tbl[3]  = '{2'b11, 2'b11, 2'b11, 4'hD, 16'hFF06, 1'b0, 8'h00, 2'b01, 1, 1, 1, 2'd1, 8'h06, 2'b00};
    tbl[4]  = '{2'b11, 2'b11, 2'b11, 4'hD, 16'hFF06, 1'b1, 8'h00, 2'b01, 1, 1, 1, 2'd1, 8'h06, 2'b01};
    tbl[5]  = '{2'b11, 2'b11, 2'b11, 4'hF, 16'hFF00, 1'b1, 8'h00, 2'b01, 1, 1, 1, 2'd3, 8'h00, 2'b01};
    tbl[6]  = '{2'b11, 2'b11, 2'b10, 4'hC, 16'hFF00, 1'b1, 8'h5A, 2'b01, 1, 1, 0, 2'd0, 8'h00, 2'b01};
    tbl[7]  = '{2'b10, 2'b10, 2'b10, 4'hC, 16'hFF00, 1'b1, 8'h00, 2'b01, 0, 0, 0, 2'd0, 8'h00, 2'b00};
    tbl[8]  = '{2'b10, 2'b10, 2'b10, 4'hC, 16'hFF00, 1'b1, 8'h00, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'b00};
    tbl[9]  = '{2'b10, 2'b10, 2'b10, 4'hC, 16'hFF00, 1'b1, 8'h00, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'b00};
    tbl[10] = '{2'b10, 2'b10, 2'b10, 4'hC, 16'hFF00, 1'b1, 8'h00, 2'b10, 1, 1, 1, 2'd3, 8'hFF, 2'b10};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 4'h0, 16'h0000, 1'b1, 8'h00, 2'b10, 0, 0, 0, 2'd0, 8'h00, 2'b00};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 4'h0, 16'h0000, 1'b0, 8'h00, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'b00};

    // Reset state
    rst_n = 0; cyc = 0; stb = 0; we = 0; adr = 0; dat = 0; wb_ack = 0; wb_dat = 0;
    #12;
    chk("rst.grant", grant_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.wb_cyc", wb_cyc_o, 0);
    chk("rst.wb_stb", wb_stb_o, 0);
    chk("rst.ack", req_ack_o, 0);
    chk("rst.err", req_err_o, 0);
    do_reset();

    // Directed table: single write, atomic burst, pending requester, release and handover
    for (int r = 0; r < 13; r++) begin
      @(posedge clk); #1;
      cyc = tbl[r].cyc; stb = tbl[r].stb; we = tbl[r].we; adr = tbl[r].adr; dat = tbl[r].dat;
      wb_ack = tbl[r].ack; wb_dat = tbl[r].rdat;
      @(negedge clk);
      chk($sformatf("tbl%0d.grant", r), grant_o, tbl[r].e_grant);
      chk($sformatf("tbl%0d.busy", r), busy_o, |tbl[r].e_grant);
      chk($sformatf("tbl%0d.wb_cyc", r), wb_cyc_o, tbl[r].e_cyc);
      chk($sformatf("tbl%0d.wb_stb", r), wb_stb_o, tbl[r].e_stb);
      chk($sformatf("tbl%0d.wb_we", r), wb_we_o, tbl[r].e_we);
      chk($sformatf("tbl%0d.wb_adr", r), wb_adr_o, tbl[r].e_adr);
      chk($sformatf("tbl%0d.wb_dat", r), wb_dat_o, tbl[r].e_dat);
      chk($sformatf("tbl%0d.ack", r), req_ack_o, tbl[r].e_ack);
      chk($sformatf("tbl%0d.rdat", r), req_dat_o, tbl[r].rdat);
    end

    // Both requesters hold cyc, each releases after one acked access
    do_reset();
    prev_ack = 0; last_g = 0; zrun = 0;
    stb = 2'b11; wb_ack = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      cyc = ~prev_ack; stb = ~prev_ack;
      @(negedge clk);
      check_all("alt");
      prev_ack = req_ack_o;
      if (grant_o == 0) zrun++;
      else begin
        if (grant_o != last_g) begin
          owners.push_back(grant_o);
          if (owners.size() > 1) gaps.push_back(zrun);
        end
        zrun = 0;
      end
      last_g = grant_o;
    end
    chk("alt.count", owners.size() >= 4, 1);
    for (int i = 0; i < 4 && i < owners.size(); i++)
      chk($sformatf("alt.owner%0d", i), owners[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int i = 0; i < 3 && i < gaps.size(); i++)
      chk($sformatf("alt.gap%0d", i), gaps[i], 2);

    // Asynchronous reset while req1 owns with stb high
    do_reset();
    cyc = 2'b10; stb = 2'b10; adr = 4'hC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("arst.pre_grant", grant_o, 2'b10);
    chk("arst.pre_cyc", wb_cyc_o, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst.wb_cyc", wb_cyc_o, 0);
    chk("arst.grant", grant_o, 0);
    chk("arst.busy", busy_o, 0);
    chk("arst.wb_stb", wb_stb_o, 0);
    #3 rst_n = 1;
    cyc = 2'b11; stb = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("arst.regrant", grant_o, 2'b01);

`ifdef WB_ARB_TIMEOUT_EN
    // Silent slave: watchdog revokes req0, req1 wins after the dead cycles
    begin
      int stb_c, err_c, g1_c;
      do_reset();
      stb_c = -1; err_c = -1; g1_c = -1;
      cyc = 2'b11; stb = 2'b01; wb_ack = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check_all("tmo");
        if (stb_c < 0 && wb_stb_o) stb_c = c;
        if (err_c < 0 && req_err_o == 2'b01) err_c = c;
        if (g1_c < 0 && grant_o == 2'b10) g1_c = c;
      end
      chk("tmo.found", (stb_c >= 0) && (err_c >= 0) && (g1_c >= 0), 1);
      chk("tmo.latency", err_c - stb_c, TMO);
      chk("tmo.dead", g1_c - err_c - 1, 2);
    end
`endif

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) cyc[k] = ~cyc[k];
      stb    = 2'($urandom);
      we     = 2'($urandom);
      adr    = 4'($urandom);
      dat    = 16'($urandom);
      wb_ack = ($urandom_range(0, 2) == 0);
      wb_dat = 8'($urandom);
      @(negedge clk);
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the single Wishbone classic slave port of the I2C multi-bus controller DUT between NUM_REQ requesters, for example a directed-test driver and a background register poller.
- Round-robin arbitration.
- The owner keeps the bus for its whole cycle (cyc high), so multi-access command sequences stay atomic.
- Sits between the requester-side Wishbone agents and the DUT in the bench top, and is synthesizable for reuse in the FPGA wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 2, Wishbone address width (the DUT has 4 byte registers).
- DATA_W, 8, Wishbone data width.
- TIMEOUT_CYC, 64, watchdog limit in clocks; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i, in, 1, system clock.
- rst_n_i, in, 1, asynchronous active-low reset.
- req_cyc_i, in, NUM_REQ, per-requester cyc.
- req_stb_i, in, NUM_REQ, per-requester stb.
- req_we_i, in, NUM_REQ, per-requester we.
- req_adr_i, in, NUM_REQ*ADDR_W, packed addresses; requester k occupies slice [k*ADDR_W +: ADDR_W].
- req_dat_i, in, NUM_REQ*DATA_W, packed write data.
- req_dat_o, out, DATA_W, read data broadcast to all requesters.
- req_ack_o, out, NUM_REQ, ack routed to the owner only.
- req_err_o, out, NUM_REQ, timeout error to the owner (constant 0 without the macro).
- wb_cyc_o, out, 1, slave-side cyc.
- wb_stb_o, out, 1, slave-side stb.
- wb_we_o, out, 1, slave-side we.
- wb_adr_o, out, ADDR_W, slave-side address.
- wb_dat_o, out, DATA_W, slave-side write data.
- wb_dat_i, in, DATA_W, slave-side read data.
- wb_ack_i, in, 1, slave-side ack.
- grant_o, out, NUM_REQ, one-hot current owner (all zero when idle).
- busy_o, out, 1, bus owned.

Behaviour:
- Reset (async, rst_n_i low):
  - FSM to IDLE, grant_o=0, busy_o=0.
  - Round-robin pointer last_q = NUM_REQ-1, so requester 0 has first priority.
  - All wb_*_o, req_ack_o and req_err_o are 0.
- FSM states: IDLE, OWN, RELEASE.
- IDLE:
  - If any req_cyc_i bit is high, select the first requesting index scanning upward from last_q+1, with modulo wrap.
  - Register grant and go to OWN. Grant latency is 1 clock after cyc is sampled.
- OWN:
  - wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o and wb_dat_o are combinational copies of the owner's inputs.
  - req_ack_o[owner] = wb_ack_i. Non-owners see ack 0.
  - req_dat_o = wb_dat_i at all times.
  - The owner may issue any number of stb accesses while its cyc stays high.
  - When the owner drops cyc: last_q <= owner, go to RELEASE.
- RELEASE:
  - One dead cycle: grant_o=0, wb_cyc_o=0.
  - Then IDLE. Re-arbitration occurs in the following IDLE cycle.
  - Minimum owner-to-owner gap is 2 clocks.
- Non-owner requests pend indefinitely; there is no preemption.
- Requests arriving together are resolved by the round-robin order.
- Sole requester: it re-wins after RELEASE with no starvation penalty.
- Owner drops cyc while stb is pending and ack has not arrived:
  - The access is abandoned and wb_cyc_o falls on that same clock.
  - A later stray wb_ack_i is ignored (no owner).
- wb_ack_i while not in OWN is ignored.
- Reset mid-transaction: outputs return to reset values immediately (asynchronously). No ack is issued.
- Packed-slice selection uses an index register of width $clog2(NUM_REQ), not multiplication in a loop.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - A counter runs in OWN while wb_stb_o=1 and wb_ack_i=0, and clears on ack.
  - When the count reaches TIMEOUT_CYC, assert req_err_o[owner] for 1 clock, force wb_stb_o=0, and go to RELEASE. The grant is revoked even if the owner's cyc is still high.
  - A revoked owner must drop cyc before it is eligible again.
- Undefined: no counter is present, req_err_o is tied to 0, and an owner may hold the bus indefinitely.

Decomposition:
- Shared package wb_arb_pkg:
  - Enum arb_state_t {IDLE, OWN, RELEASE}.
  - Function rr_pick(req, last) returning the next index.
  - Constants for the default widths.
- One natural sub-module, wb_rr_pick: combinational round-robin selector (request vector + last index -> index + valid). It is unit-testable and reusable by other arbiters in the environment.

Test Plan:
- Reset, then req0 asserts cyc at t0 -> grant_o=01 at t0+1. A write to adr 2 with dat 0x8C appears on wb_*_o. wb_ack_i pulses and the ack reaches req_ack_o[0] only.
- req0 and req1 assert cyc in the same clock after reset -> req0 is granted first. After req0 drops cyc: one RELEASE cycle, then IDLE, then grant_o=10.
- req0 owns the bus and performs 3 back-to-back accesses (write 0x06, write 0x00, read adr 0 returning 0x5A) -> grant is held through all three and req_dat_o=0x5A on the read ack. req1 stays pending with ack 0.
- Both requesters hold cyc continuously, each releasing after one access -> grants alternate 01, 10, 01, 10 with a 2-clock gap between owners.
- rst_n_i pulled low while req1 owns the bus with stb high -> wb_cyc_o, grant_o and busy_o go to 0 without waiting for a clock edge. After release, req0 is granted first.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, and the slave never acking -> req_err_o[owner] pulses 8 clocks after stb rises, then wb_stb_o=0, then RELEASE. The other requester is granted 2 clocks later.
